uart_rx_ctrl: RTL and testbench
===============================

# uart_rx_ctrl

Receive-side frame controller for the UART RX path. It detects a start bit on the serial line and enables and sequences the edge/bit counter. From the counter position it issues the sample, deserialize and check strobes for the start, data, parity and stop bits. At the end of each frame it emits a single-cycle data-valid pulse plus registered error flags. It sits between the serial input and the RX datapath (counter, sampler, deserializer, checkers) inside UART_RX.

## Interface
- DATA_WIDTH, 8, data bits per frame; legal range 5..13, because bit index DATA_WIDTH+2 must fit the 4-bit bit counter.
- CLK  in  1  oversampling clock.
- RST  in  1  asynchronous, active-high reset.
- RX_IN  in  1  serial line; idle is high.
- PAR_EN  in  1  frame carries a parity bit; static while busy.
- Prescale  in  6  oversampling ratio; legal values 8, 16, 32; static while busy.
- bit_cnt  in  4  bit index from the edge/bit counter.
- edge_cnt  in  6  edge index within the current bit, from the edge/bit counter.
- strt_glitch  in  1  start checker result; valid in the cycle strt_chk_en is high.
- par_err  in  1  parity checker result; valid in the cycle par_chk_en is high.
- stp_err  in  1  stop checker result; valid in the cycle stp_chk_en is high.
- edge_bit_en  out  1  enable for the edge/bit counter.
- dat_samp_en  out  1  enable for the majority sampler.
- deser_en  out  1  shift strobe for the deserializer.
- strt_chk_en, par_chk_en, stp_chk_en  out  1 each  checker strobes.
- data_valid  out  1  one-cycle pulse: a frame was received with no error.
- par_error, stop_error  out  1 each  error status of the most recent frame.
- busy  out  1  high when the state is not IDLE.

## Operation
- States: IDLE, START, DATA, PARITY, STOP, DONE. The state register is encoded in 3 bits.
- Definitions:
  - bit_end = (edge_cnt == Prescale-1).
  - chk_pt = (edge_cnt == (Prescale>>1)+2). This is the first edge after the three majority samples at Prescale/2-1, Prescale/2 and Prescale/2+1.
- Output decoding:
  - edge_bit_en and dat_samp_en: high in START, DATA, PARITY and STOP; low in IDLE and DONE. Deasserting edge_bit_en clears the counter.
  - Strobes, each a combinational decode of state & chk_pt:
    - START: strt_chk_en.
    - DATA: deser_en.
    - PARITY: par_chk_en.
    - STOP: stp_chk_en.
- Transitions:
  - IDLE→START when RX_IN==0.
  - START→IDLE at chk_pt if strt_glitch (false start).
  - START→DATA at bit_end.
  - DATA→PARITY at bit_end when bit_cnt==DATA_WIDTH and PAR_EN==1.
  - DATA→STOP under the same condition with PAR_EN==0.
  - PARITY→STOP at bit_end.
  - STOP→DONE at chk_pt. The controller does not wait for the remainder of the stop bit.
  - DONE→START if RX_IN==0, otherwise DONE→IDLE. DONE always lasts one cycle.
- Error flags:
  - A sticky internal flag captures par_err when par_chk_en is high. It is cleared on entry to START.
  - On STOP→DONE: par_error is loaded from the sticky flag, stop_error is loaded from stp_err, and data_valid is set to !(sticky | stp_err).
  - par_error and stop_error hold until the next DONE.
- A false start produces no data_valid and does not change the error flags.

## Timing
- Reset: state IDLE; all outputs 0 (data_valid, par_error, stop_error, busy, all enables and strobes).
- RST asserted mid-frame: the controller returns to IDLE immediately. The frame is discarded with no data_valid.
- All strobes are combinational from registered state and the counter inputs. data_valid, par_error and stop_error are registered.
- Latency: START is entered on the cycle after RX_IN is first seen low. Call the START entry cycle t0 (edge_cnt=0, bit_cnt=0). data_valid is high in cycle:
  - t0+8·(DATA_WIDTH+2)+(Prescale>>1)+3 with parity, evaluated with Prescale=8;
  - in general t0 + Prescale·(DATA_WIDTH+1+PAR_EN) + (Prescale>>1) + 3.
- Back-to-back frames: a start bit that falls during the stop-bit tail or in DONE is accepted on the DONE→START transition, with a one-cycle phase offset.
- Changing Prescale or PAR_EN while busy is unsupported; the result is undefined.

## Configuration
- UART_RX_PARITY_EN:
  - Defined: the PARITY state, par_chk_en, par_error and PAR_EN are implemented.
  - Undefined: DATA goes straight to STOP; par_chk_en and par_error are tied to 0; PAR_EN is ignored.

## Structure
- The shared package uart_rx_pkg holds:
  - the state enum type uart_rx_state_t;
  - the constants for legal Prescale values;
  - the DATA_WIDTH bound check.
- One sub-module, uart_rx_strobe_dec: the chk_pt/bit_end comparators and the strobe decode. It is instantiated once.

## Test plan
- Prescale=8, PAR_EN=1, frame 0xA5 with even parity, all checkers clean:
  - data_valid is high for exactly one cycle at t0+87;
  - deser_en pulses 8 times, at edge_cnt==6;
  - par_error=0 and stop_error=0.
- Same frame with PAR_EN=0: data_valid at t0+79; par_chk_en never asserts.
- strt_glitch=1 at the START check point: back to IDLE at t0+7; edge_bit_en drops; no data_valid.
- par_err=1 at par_chk_en: no data_valid; par_error=1 after DONE, held until the next clean frame clears it.
- stp_err=1: no data_valid; stop_error=1. A following clean frame restores stop_error=0 and pulses data_valid.
- RST pulsed mid-DATA (bit_cnt=4), then two back-to-back frames with RX_IN low in DONE:
  - immediate IDLE with all outputs 0;
  - two data_valid pulses, the second frame entering START directly from DONE.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART RX frame controller.
// The optional parity path is selected with the UART_RX_PARITY_EN macro.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_DONE   = 3'd5
    } uart_rx_state_t;

    localparam logic [5:0] PRESCALE_X8  = 6'd8;
    localparam logic [5:0] PRESCALE_X16 = 6'd16;
    localparam logic [5:0] PRESCALE_X32 = 6'd32;

    // Bit index DATA_WIDTH+2 (the stop bit) must fit the 4-bit bit counter.
    localparam int DATA_WIDTH_MIN = 5;
    localparam int DATA_WIDTH_MAX = 13;

    function automatic bit data_width_ok(input int dw);
        return (dw >= DATA_WIDTH_MIN) && (dw <= DATA_WIDTH_MAX);
    endfunction

    function automatic bit prescale_ok(input logic [5:0] p);
        return (p == PRESCALE_X8) || (p == PRESCALE_X16) || (p == PRESCALE_X32);
    endfunction

endpackage

// File: rtl/uart_rx_strobe_dec.sv
// Bit-position comparators and per-state check/shift strobe decode.
// The three majority samples sit at Prescale/2-1..Prescale/2+1, so chk_pt is the edge after them.
module uart_rx_strobe_dec
    import uart_rx_pkg::*;
(
    input  uart_rx_state_t state_i,
    input  logic [5:0]     prescale_i,
    input  logic [5:0]     edge_cnt_i,
    output logic           bit_end_o,
    output logic           chk_pt_o,
    output logic           strt_chk_en_o,
    output logic           deser_en_o,
    output logic           par_chk_en_o,
    output logic           stp_chk_en_o
);

    assign bit_end_o = (edge_cnt_i == (prescale_i - 6'd1));
    assign chk_pt_o  = (edge_cnt_i == ((prescale_i >> 1) + 6'd2));

    assign strt_chk_en_o = chk_pt_o && (state_i == ST_START);
    assign deser_en_o    = chk_pt_o && (state_i == ST_DATA);
    assign par_chk_en_o  = chk_pt_o && (state_i == ST_PARITY);
    assign stp_chk_en_o  = chk_pt_o && (state_i == ST_STOP);

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART RX frame controller: start detect, counter sequencing, strobes, frame status.
// Parity support (PARITY state, par_chk_en, par_error) exists only with UART_RX_PARITY_EN defined.
module uart_rx_ctrl
    import uart_rx_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       RX_IN,
    input  logic       PAR_EN,
    input  logic [5:0] Prescale,
    input  logic [3:0] bit_cnt,
    input  logic [5:0] edge_cnt,
    input  logic       strt_glitch,
    input  logic       par_err,
    input  logic       stp_err,
    output logic       edge_bit_en,
    output logic       dat_samp_en,
    output logic       deser_en,
    output logic       strt_chk_en,
    output logic       par_chk_en,
    output logic       stp_chk_en,
    output logic       data_valid,
    output logic       par_error,
    output logic       stop_error,
    output logic       busy
);

    if (!data_width_ok(DATA_WIDTH)) begin : g_dw_check
        $error("uart_rx_ctrl: DATA_WIDTH %0d out of range", DATA_WIDTH);
    end

    uart_rx_state_t state_q, state_d;
    logic bit_end, chk_pt, par_chk_dec, last_data, par_on, stop_done;
    logic data_valid_q, data_valid_d;
    logic stop_error_q, stop_error_d;
    logic par_flag;

    uart_rx_strobe_dec u_strobe_dec (
        .state_i       (state_q),
        .prescale_i    (Prescale),
        .edge_cnt_i    (edge_cnt),
        .bit_end_o     (bit_end),
        .chk_pt_o      (chk_pt),
        .strt_chk_en_o (strt_chk_en),
        .deser_en_o    (deser_en),
        .par_chk_en_o  (par_chk_dec),
        .stp_chk_en_o  (stp_chk_en)
    );

    assign last_data = (bit_cnt == 4'(DATA_WIDTH));
    assign stop_done = stp_chk_en;

`ifdef UART_RX_PARITY_EN
    logic par_sticky_q, par_sticky_d;
    logic par_error_q, par_error_d;

    assign par_on     = PAR_EN;
    assign par_chk_en = par_chk_dec;
    assign par_flag   = par_sticky_q;
    assign par_error  = par_error_q;

    // Sticky flag starts clean at every START entry, including DONE->START.
    always_comb begin
        par_sticky_d = par_sticky_q;
        if (state_d == ST_START && state_q != ST_START)
            par_sticky_d = 1'b0;
        else if (par_chk_en && par_err)
            par_sticky_d = 1'b1;
        par_error_d = stop_done ? par_sticky_q : par_error_q;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            par_sticky_q <= 1'b0;
            par_error_q  <= 1'b0;
        end else begin
            par_sticky_q <= par_sticky_d;
            par_error_q  <= par_error_d;
        end
    end
`else
    logic unused_par;
    assign unused_par = ^{PAR_EN, par_err, par_chk_dec};
    assign par_on     = 1'b0;
    assign par_chk_en = 1'b0;
    assign par_flag   = 1'b0;
    assign par_error  = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:   if (!RX_IN) state_d = ST_START;
            ST_START: begin
                if (chk_pt && strt_glitch) state_d = ST_IDLE;
                else if (bit_end)          state_d = ST_DATA;
            end
            ST_DATA:   if (bit_end && last_data) state_d = par_on ? ST_PARITY : ST_STOP;
            ST_PARITY: if (bit_end) state_d = ST_STOP;
            ST_STOP:   if (chk_pt)  state_d = ST_DONE;
            ST_DONE:   state_d = RX_IN ? ST_IDLE : ST_START;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        data_valid_d = stop_done && !(par_flag || stp_err);
        stop_error_d = stop_done ? stp_err : stop_error_q;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q      <= ST_IDLE;
            data_valid_q <= 1'b0;
            stop_error_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            data_valid_q <= data_valid_d;
            stop_error_q <= stop_error_d;
        end
    end

    assign edge_bit_en = (state_q == ST_START) || (state_q == ST_DATA) ||
                         (state_q == ST_PARITY) || (state_q == ST_STOP);
    assign dat_samp_en = edge_bit_en;
    assign busy        = (state_q != ST_IDLE);
    assign data_valid  = data_valid_q;
    assign stop_error  = stop_error_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: emulates the edge/bit counter and checks frame timing and status.
module tb_uart_rx_ctrl;

`ifdef UART_RX_PARITY_EN
    localparam bit PAR_BUILT = 1'b1;
`else
    localparam bit PAR_BUILT = 1'b0;
`endif

    logic       CLK = 1'b0;
    logic       RST, RX_IN, PAR_EN, strt_glitch, par_err, stp_err;
    logic [5:0] Prescale, edge_cnt;
    logic [3:0] bit_cnt;
    logic       edge_bit_en, dat_samp_en, deser_en, strt_chk_en, par_chk_en, stp_chk_en;
    logic       data_valid, par_error, stop_error, busy;

    uart_rx_ctrl #(.DATA_WIDTH(8)) dut (
        .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .PAR_EN(PAR_EN), .Prescale(Prescale),
        .bit_cnt(bit_cnt), .edge_cnt(edge_cnt), .strt_glitch(strt_glitch),
        .par_err(par_err), .stp_err(stp_err), .edge_bit_en(edge_bit_en),
        .dat_samp_en(dat_samp_en), .deser_en(deser_en), .strt_chk_en(strt_chk_en),
        .par_chk_en(par_chk_en), .stp_chk_en(stp_chk_en), .data_valid(data_valid),
        .par_error(par_error), .stop_error(stop_error), .busy(busy)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    // Edge/bit counter the controller drives in the real datapath.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST || !edge_bit_en) begin
            edge_cnt <= '0;
            bit_cnt  <= '0;
        end else if (edge_cnt == Prescale - 6'd1) begin
            edge_cnt <= '0;
            bit_cnt  <= bit_cnt + 4'd1;
        end else begin
            edge_cnt <= edge_cnt + 6'd1;
        end
    end

    int n_checks = 0;
    int n_fail   = 0;
    bit m_par_error = 1'b0;
    bit m_stop_error = 1'b0;
    int next_t0 = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic wave_bit(input int off, input int p, input bit pe, input logic [7:0] d);
        int b;
        b = off / p;
        if (b == 0) return 1'b0;
        if (b <= 8) return d[b-1];
        if (b == 9 && pe) return ^d;
        return 1'b1;
    endfunction

    task automatic run_frame(input string tag, input int p, input bit pe, input logic [7:0] d,
                             input bit glitch, input bit perr, input bit serr,
                             input bit chain_in, input bit chain_out);
        int t0, lat, dv_cnt, dv_cyc, deser_cnt, deser_bad, par_cnt, strt_cnt, stp_cnt, drop_cyc;
        bit pe_eff, exp_pe, exp_dv, done;
        pe_eff = pe && PAR_BUILT;
        lat = p * (9 + int'(pe_eff)) + p / 2 + 3;
        strt_glitch = glitch;
        par_err = perr;
        stp_err = serr;
        if (!chain_in) begin
            @(negedge CLK);
            check($sformatf("%s idle_before", tag), busy, 0);
            Prescale = 6'(p);
            PAR_EN = pe;
            RX_IN = 1'b0;
            t0 = cyc + 1;
        end else begin
            t0 = next_t0;
        end
        dv_cnt = 0; dv_cyc = -1; deser_cnt = 0; deser_bad = 0; par_cnt = 0;
        strt_cnt = 0; stp_cnt = 0; drop_cyc = -1; done = 1'b0;
        for (int n = 0; n < lat + 2 * p + 10 && !done; n++) begin
            @(negedge CLK);
            if (deser_en) begin
                deser_cnt++;
                if (int'(edge_cnt) != p / 2 + 2 || bit_cnt < 4'd1 || bit_cnt > 4'd8) deser_bad++;
            end
            if (par_chk_en) par_cnt++;
            if (strt_chk_en) strt_cnt++;
            if (stp_chk_en) stp_cnt++;
            if (data_valid) begin
                dv_cnt++;
                dv_cyc = cyc;
                if (chain_out) begin
                    RX_IN = 1'b0;
                    next_t0 = cyc + 1;
                    done = 1'b1;
                end
            end
            if (!busy && cyc >= t0) begin
                drop_cyc = cyc;
                done = 1'b1;
            end
            if (!done) begin
                if (glitch) RX_IN = (cyc + 1 - t0 < 2) ? 1'b0 : 1'b1;
                else        RX_IN = wave_bit(cyc + 1 - t0, p, pe, d);
            end
        end
        check($sformatf("%s completed", tag), 32'(done), 1);
        check($sformatf("%s strt_chk_count", tag), strt_cnt, 1);
        if (glitch) begin
            check($sformatf("%s idle_cycle", tag), drop_cyc, t0 + p / 2 + 3);
            check($sformatf("%s dv_count", tag), dv_cnt, 0);
            check($sformatf("%s edge_bit_en", tag), edge_bit_en, 0);
            check($sformatf("%s deser_count", tag), deser_cnt, 0);
        end else begin
            exp_pe = pe_eff && perr;
            exp_dv = !(exp_pe || serr);
            m_par_error = exp_pe;
            m_stop_error = serr;
            check($sformatf("%s dv_count", tag), dv_cnt, int'(exp_dv));
            if (exp_dv) check($sformatf("%s dv_cycle", tag), dv_cyc, t0 + lat);
            if (!chain_out || !exp_dv) check($sformatf("%s busy_drop", tag), drop_cyc, t0 + lat + 1);
            check($sformatf("%s deser_count", tag), deser_cnt, 8);
            check($sformatf("%s deser_edge", tag), deser_bad, 0);
            check($sformatf("%s par_chk_count", tag), par_cnt, int'(pe_eff));
            check($sformatf("%s stp_chk_count", tag), stp_cnt, 1);
        end
        check($sformatf("%s par_error", tag), par_error, m_par_error);
        check($sformatf("%s stop_error", tag), stop_error, m_stop_error);
    endtask

    initial begin
        int p;
        bit found;
        RST = 1'b1; RX_IN = 1'b1; PAR_EN = 1'b0; Prescale = 6'd8;
        strt_glitch = 1'b0; par_err = 1'b0; stp_err = 1'b0;
        repeat (3) @(negedge CLK);
        check("reset busy", busy, 0);
        check("reset edge_bit_en", edge_bit_en, 0);
        check("reset dat_samp_en", dat_samp_en, 0);
        check("reset strobes", {deser_en, strt_chk_en, par_chk_en, stp_chk_en}, 0);
        check("reset data_valid", data_valid, 0);
        check("reset flags", {par_error, stop_error}, 0);
        RST = 1'b0;
        repeat (2) @(negedge CLK);

        run_frame("a5_par",    8, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        run_frame("a5_nopar",  8, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        run_frame("glitch",    8, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        run_frame("par_err",   8, 1'b1, 8'h3C, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        run_frame("glitch2",  16, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        run_frame("clean1",    8, 1'b1, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        run_frame("stp_err",  16, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        run_frame("clean2",   16, 1'b0, 8'h81, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        run_frame("stp_err2",  8, 1'b1, 8'h11, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

        // Mid-frame reset while in DATA at bit 4.
        @(negedge CLK);
        Prescale = 6'd8; PAR_EN = 1'b1; RX_IN = 1'b0;
        found = 1'b0;
        for (int n = 0; n < 200 && !found; n++) begin
            @(negedge CLK);
            RX_IN = 1'b1;
            if (busy && bit_cnt == 4'd4) found = 1'b1;
        end
        check("rst reached_bit4", bit_cnt, 4);
        RST = 1'b1;
        #1;
        check("rst busy", busy, 0);
        check("rst edge_bit_en", {edge_bit_en, dat_samp_en}, 0);
        check("rst strobes", {deser_en, strt_chk_en, par_chk_en, stp_chk_en}, 0);
        check("rst outputs", {data_valid, par_error, stop_error}, 0);
        m_par_error = 1'b0;
        m_stop_error = 1'b0;
        @(negedge CLK);
        RST = 1'b0;
        repeat (3) @(negedge CLK);
        check("post_rst data_valid", data_valid, 0);

        run_frame("b2b_first",  8, 1'b1, 8'hC3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("b2b done_state_busy", busy, 1);
        run_frame("b2b_second", 8, 1'b1, 8'h69, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        for (int i = 0; i < 6; i++) begin
            case ($urandom_range(0, 2))
                0: p = 8;
                1: p = 16;
                default: p = 32;
            endcase
            run_frame($sformatf("rnd%0d", i), p, 1'($urandom_range(0, 1)), 8'($urandom),
                      $urandom_range(0, 6) == 0, $urandom_range(0, 3) == 0,
                      $urandom_range(0, 3) == 0, 1'b0, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
